// File: rtl/capture_counter_pkg.sv
// Shared definitions for the capture counter: count direction encodings and
// the per-channel capture action decode.
package capture_counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [2:0] {
    CAP_IDLE,
    CAP_FIRST,
    CAP_OVERRUN,
    CAP_CLEAR,
    CAP_RESTART
  } cap_op_e;

  // A clear in the same cycle as a capture acts as clear-then-capture, so the
  // fresh sample is valid with no overrun.
  function automatic cap_op_e cap_decode(input logic cap, input logic clr, input logic vld);
    cap_op_e op;
    op = CAP_IDLE;
    if (clr && cap) begin
      op = CAP_RESTART;
    end else if (clr) begin
      op = CAP_CLEAR;
    end else if (cap) begin
      op = vld ? CAP_OVERRUN : CAP_FIRST;
    end
    return op;
  endfunction

endpackage

// File: rtl/capture_counter_if.sv
// Control, counter and capture signals of the capture counter, grouped as one bus.
interface capture_counter_if #(
  parameter int WIDTH = 32,
  parameter int N_CAP = 2
);

  logic                   en;
  logic                   dir;
  logic                   load;
  logic [WIDTH-1:0]       load_val;
  logic [WIDTH-1:0]       limit;
  logic [N_CAP-1:0]       cap;
  logic [N_CAP-1:0]       cap_clr;
  logic [WIDTH-1:0]       cnt;
  logic                   wrap;
  logic [N_CAP*WIDTH-1:0] cap_val;
  logic [N_CAP-1:0]       cap_vld;
  logic [N_CAP-1:0]       cap_ovr;

  modport master (
    output en, dir, load, load_val, limit, cap, cap_clr,
    input  cnt, wrap, cap_val, cap_vld, cap_ovr
  );

  modport slave (
    input  en, dir, load, load_val, limit, cap, cap_clr,
    output cnt, wrap, cap_val, cap_vld, cap_ovr
  );

endinterface

// File: rtl/capture_counter_cap_channel.sv
// One capture channel: a timestamp register with valid and sticky overrun flags.
module capture_counter_cap_channel
  import capture_counter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cap,
  input  logic             cap_clr,
  input  logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] val,
  output logic             vld,
  output logic             ovr
);

  logic [WIDTH-1:0] val_q, val_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  cap_op_e          op;

  assign op = cap_decode(cap, cap_clr, vld_q);

  always_comb begin
    val_d = val_q;
    vld_d = vld_q;
    ovr_d = ovr_q;
    unique case (op)
      CAP_FIRST: begin
        val_d = cnt;
        vld_d = 1'b1;
      end
      // Newest sample replaces the unread one; the loss is recorded in ovr.
      CAP_OVERRUN: begin
        val_d = cnt;
        ovr_d = 1'b1;
      end
      CAP_CLEAR: begin
        vld_d = 1'b0;
        ovr_d = 1'b0;
      end
      CAP_RESTART: begin
        val_d = cnt;
        vld_d = 1'b1;
        ovr_d = 1'b0;
      end
      default: begin
        val_d = val_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      val_q <= val_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

  assign val = val_q;
  assign vld = vld_q;
  assign ovr = ovr_q;

endmodule

// File: rtl/capture_counter.sv
// Up/down cycle counter with runtime wrap limit, parallel load and N_CAP
// independent timestamp capture channels.
module capture_counter
  import capture_counter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_CAP = 2
) (
  input  logic              clk,
  input  logic              reset,
  capture_counter_if.slave  bus
);

  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic                   wrap_q, wrap_d;
  logic [N_CAP*WIDTH-1:0] cap_val_w;
  logic [N_CAP-1:0]       cap_vld_w;
  logic [N_CAP-1:0]       cap_ovr_w;

  // Wrap is decided by comparison against limit before any arithmetic, so an
  // all-ones limit behaves as a plain modulo counter with no overflow path.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (bus.load) begin
      cnt_d = bus.load_val;
    end else if (bus.en) begin
      case (bus.dir)
        DIR_UP: begin
          if (cnt_q >= bus.limit) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        DIR_DOWN: begin
          if (cnt_q == '0) begin
            cnt_d  = bus.limit;
            wrap_d = 1'b1;
          end else begin
            cnt_d = cnt_q - WIDTH'(1);
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // Channels sample the registered count, i.e. the value shown on cnt in the
  // cycle the strobe is high, independent of load/en on the same edge.
  generate
    for (genvar gi = 0; gi < N_CAP; gi++) begin : g_cap
      capture_counter_cap_channel #(
        .WIDTH (WIDTH)
      ) u_chan (
        .clk     (clk),
        .reset   (reset),
        .cap     (bus.cap[gi]),
        .cap_clr (bus.cap_clr[gi]),
        .cnt     (cnt_q),
        .val     (cap_val_w[gi*WIDTH +: WIDTH]),
        .vld     (cap_vld_w[gi]),
        .ovr     (cap_ovr_w[gi])
      );
    end
  endgenerate

  assign bus.cnt     = cnt_q;
  assign bus.wrap    = wrap_q;
  assign bus.cap_val = cap_val_w;
  assign bus.cap_vld = cap_vld_w;
  assign bus.cap_ovr = cap_ovr_w;

endmodule

// File: tb/tb_capture_counter.sv
// Directed bench for capture_counter: each step queues its hand-computed
// post-edge outputs; a negedge monitor pops and compares them.
module tb_capture_counter;

  localparam int          W    = 32;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  typedef struct {
    int unsigned tag;
    string       name;
    logic [31:0] cnt;
    logic        wrap;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [1:0]  vld;
    logic [1:0]  ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned edge_num = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];

  capture_counter_if #(.WIDTH(W), .N_CAP(2)) bus ();

  capture_counter #(.WIDTH(W), .N_CAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_num = edge_num + 1;

  task automatic chk(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", nm, field, act, exp);
    end
  endtask

  // Monitor: compares the outputs produced by the edge an entry was issued for.
  always @(negedge clk) begin
    if (sb_q.size() > 0 && sb_q[0].tag == edge_num) begin
      exp_t e;
      e = sb_q.pop_front();
      $display("txn %-10s cnt=%h wrap=%b v0=%h v1=%h vld=%b ovr=%b",
               e.name, bus.cnt, bus.wrap, bus.cap_val[31:0], bus.cap_val[63:32],
               bus.cap_vld, bus.cap_ovr);
      chk(e.name, "cnt",  bus.cnt, e.cnt);
      chk(e.name, "wrap", {31'd0, bus.wrap}, {31'd0, e.wrap});
      chk(e.name, "v0",   bus.cap_val[31:0], e.v0);
      chk(e.name, "v1",   bus.cap_val[63:32], e.v1);
      chk(e.name, "vld",  {30'd0, bus.cap_vld}, {30'd0, e.vld});
      chk(e.name, "ovr",  {30'd0, bus.cap_ovr}, {30'd0, e.ovr});
    end
  end

  task automatic step(
    input logic r, input logic e, input logic d, input logic ld,
    input logic [31:0] lv, input logic [31:0] lim,
    input logic [1:0] c, input logic [1:0] cc,
    input logic [31:0] ecnt, input logic ewrap,
    input logic [31:0] ev0, input logic [31:0] ev1,
    input logic [1:0] evld, input logic [1:0] eovr,
    input string nm
  );
    exp_t x;
    reset        = r;
    bus.en       = e;
    bus.dir      = d;
    bus.load     = ld;
    bus.load_val = lv;
    bus.limit    = lim;
    bus.cap      = c;
    bus.cap_clr  = cc;
    x.tag  = edge_num + 1;
    x.name = nm;
    x.cnt  = ecnt;
    x.wrap = ewrap;
    x.v0   = ev0;
    x.v1   = ev1;
    x.vld  = evld;
    x.ovr  = eovr;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //    r  e  d  ld lv    lim    cap    clr    | cnt   w  v0    v1    vld    ovr
    step(1, 0, 0, 0, 0,    ONES,  2'b00, 2'b00,   0,    0, 0,    0,    2'b00, 2'b00, "reset0");
    step(1, 0, 0, 0, 0,    ONES,  2'b00, 2'b00,   0,    0, 0,    0,    2'b00, 2'b00, "reset1");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   1,    0, 0,    0,    2'b00, 2'b00, "up1");
    step(0, 1, 0, 0, 0,    ONES,  2'b01, 2'b00,   2,    0, 1,    0,    2'b01, 2'b00, "cap0");
    step(0, 1, 0, 0, 0,    ONES,  2'b10, 2'b00,   3,    0, 1,    2,    2'b11, 2'b00, "cap1");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b01,   4,    0, 1,    2,    2'b10, 2'b00, "clr0");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   5,    0, 1,    2,    2'b10, 2'b00, "up5");
    step(0, 1, 0, 0, 0,    ONES,  2'b01, 2'b00,   6,    0, 5,    2,    2'b11, 2'b00, "cap0_5");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   7,    0, 5,    2,    2'b11, 2'b00, "up7");
    step(0, 1, 0, 0, 0,    ONES,  2'b01, 2'b00,   8,    0, 7,    2,    2'b11, 2'b01, "ovr0");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b01,   9,    0, 7,    2,    2'b10, 2'b00, "clr0b");
    step(0, 1, 0, 1, 100,  ONES,  2'b01, 2'b00,   100,  0, 9,    2,    2'b11, 2'b00, "load_cap");
    step(0, 1, 0, 0, 0,    ONES,  2'b10, 2'b00,   101,  0, 9,    100,  2'b11, 2'b10, "ovr1");
    step(0, 1, 0, 0, 0,    ONES,  2'b10, 2'b10,   102,  0, 9,    101,  2'b11, 2'b00, "capclr1");
    step(0, 0, 0, 0, 0,    ONES,  2'b00, 2'b00,   102,  0, 9,    101,  2'b11, 2'b00, "hold");
    step(0, 0, 0, 1, 0,    3,     2'b00, 2'b00,   0,    0, 9,    101,  2'b11, 2'b00, "load0");
    step(0, 1, 0, 0, 0,    3,     2'b00, 2'b00,   1,    0, 9,    101,  2'b11, 2'b00, "lim3_1");
    step(0, 1, 0, 0, 0,    3,     2'b00, 2'b00,   2,    0, 9,    101,  2'b11, 2'b00, "lim3_2");
    step(0, 1, 0, 0, 0,    3,     2'b00, 2'b00,   3,    0, 9,    101,  2'b11, 2'b00, "lim3_3");
    step(0, 1, 0, 0, 0,    3,     2'b00, 2'b00,   0,    1, 9,    101,  2'b11, 2'b00, "wrap_up");
    step(0, 1, 1, 0, 0,    3,     2'b00, 2'b00,   3,    1, 9,    101,  2'b11, 2'b00, "wrap_dn");
    step(0, 1, 1, 0, 0,    3,     2'b00, 2'b00,   2,    0, 9,    101,  2'b11, 2'b00, "dn2");
    step(0, 0, 0, 1, 10,   3,     2'b00, 2'b00,   10,   0, 9,    101,  2'b11, 2'b00, "load_over");
    step(0, 1, 0, 0, 0,    3,     2'b00, 2'b00,   0,    1, 9,    101,  2'b11, 2'b00, "over_wrap");
    step(0, 1, 0, 0, 0,    0,     2'b00, 2'b00,   0,    1, 9,    101,  2'b11, 2'b00, "lim0_up");
    step(0, 1, 1, 0, 0,    0,     2'b00, 2'b00,   0,    1, 9,    101,  2'b11, 2'b00, "lim0_dn");
    step(0, 1, 1, 0, 0,    ONES,  2'b00, 2'b00,   ONES, 1, 9,    101,  2'b11, 2'b00, "dn_full");
    step(0, 1, 1, 0, 0,    ONES,  2'b11, 2'b00,   32'hFFFF_FFFE, 0, ONES, ONES, 2'b11, 2'b11, "cap_both");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   ONES, 0, ONES, ONES, 2'b11, 2'b11, "up_max");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   0,    1, ONES, ONES, 2'b11, 2'b11, "up_full");
    step(0, 0, 0, 0, 0,    ONES,  2'b00, 2'b11,   0,    0, ONES, ONES, 2'b00, 2'b00, "clr_both");
    step(0, 0, 0, 1, 42,   ONES,  2'b00, 2'b00,   42,   0, ONES, ONES, 2'b00, 2'b00, "load42");
    step(0, 0, 0, 0, 0,    ONES,  2'b01, 2'b00,   42,   0, 42,   ONES, 2'b01, 2'b00, "cap42");
    step(1, 1, 0, 1, 7,    ONES,  2'b11, 2'b00,   0,    0, 0,    0,    2'b00, 2'b00, "reset_mid");
    step(0, 1, 0, 0, 0,    ONES,  2'b00, 2'b00,   1,    0, 0,    0,    2'b00, 2'b00, "resume");

    reset       = 1'b0;
    bus.en      = 1'b0;
    bus.load    = 1'b0;
    bus.cap     = 2'b00;
    bus.cap_clr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation still running at %0t, limit 20000", $time);
    $fatal(1, "timeout");
  end

endmodule
